systolic_feeder: RTL



---
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: operand scheduler for the 2x2 output-stationary array.
// Latches one A/B pair, clears the PEs, feeds skewed edges, then signals done.
module systolic_feeder #(
    parameter int DW    = 16,
    parameter int DRAIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] a_mat,
    input  logic [4*DW-1:0] b_mat,
    output logic [DW-1:0]   a_row0,
    output logic [DW-1:0]   a_row1,
    output logic [1:0]      a_vld,
    output logic [DW-1:0]   b_col0,
    output logic [DW-1:0]   b_col1,
    output logic [1:0]      b_vld,
    output logic            acc_clr,
    output logic            busy,
    output logic            done,
    output logic [7:0]      job_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] DLAST = 4'(DRAIN - 1);

    state_t          state;
    state_t          state_nx;
    logic [1:0]      beat;
    logic [3:0]      dcnt;
    logic [4*DW-1:0] a_q;
    logic [4*DW-1:0] b_q;
    logic            take;

    assign take = in_valid & (state == S_IDLE);

    // State register; reset returns to IDLE and aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state sequencing: fixed-length phases, no early exits.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (in_valid) state_nx = S_CLEAR;
            S_CLEAR: state_nx = S_FEED;
            S_FEED:  if (beat == 2'd2) state_nx = S_DRAIN;
            S_DRAIN: if (dcnt == DLAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture on transfer; held untouched until the next job.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (take) begin
            a_q <= a_mat;
            b_q <= b_mat;
        end
    end

    // Feed beat and drain interval counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            dcnt <= '0;
        end else begin
            unique case (state)
                S_CLEAR: beat <= 2'd0;
                S_FEED: begin
                    beat <= beat + 2'd1;
                    dcnt <= 4'd0;
                end
                S_DRAIN: dcnt <= dcnt + 4'd1;
                default: begin
                    beat <= beat;
                    dcnt <= dcnt;
                end
            endcase
        end
    end

    // Completed-job counter, bumped as the DONE cycle ends; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt <= '0;
        end else if (state == S_DONE) begin
            job_cnt <= job_cnt + 8'd1;
        end
    end

    // Moore output decode; row/column k is fed element (beat - k).
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        acc_clr  = 1'b0;
        done     = 1'b0;
        a_row0   = '0;
        a_row1   = '0;
        b_col0   = '0;
        b_col1   = '0;
        a_vld    = 2'b00;
        b_vld    = 2'b00;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_CLEAR: acc_clr = 1'b1;
            S_FEED: begin
                unique case (beat)
                    2'd0: begin
                        a_row0 = a_q[0*DW +: DW];
                        b_col0 = b_q[0*DW +: DW];
                        a_vld  = 2'b01;
                        b_vld  = 2'b01;
                    end
                    2'd1: begin
                        a_row0 = a_q[1*DW +: DW];
                        a_row1 = a_q[2*DW +: DW];
                        b_col0 = b_q[2*DW +: DW];
                        b_col1 = b_q[1*DW +: DW];
                        a_vld  = 2'b11;
                        b_vld  = 2'b11;
                    end
                    2'd2: begin
                        a_row1 = a_q[3*DW +: DW];
                        b_col1 = b_q[3*DW +: DW];
                        a_vld  = 2'b10;
                        b_vld  = 2'b10;
                    end
                    default: begin
                        a_vld = 2'b00;
                        b_vld = 2'b00;
                    end
                endcase
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

endmodule
